// File: rtl/cfs_stream_packer.sv
// Packs RATIO consecutive DATA_WIDTH input words into one wide word behind a registered valid/ready output.
// Optional partial-word flush is compiled in with `define CFS_STREAM_PACKER_FLUSH_EN.
module cfs_stream_packer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int RATIO      = 4,
  localparam int CNT_WIDTH  = $clog2(RATIO + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [CNT_WIDTH-1:0]        out_cnt,
  input  logic                        out_ready
`ifdef CFS_STREAM_PACKER_FLUSH_EN
  ,
  input  logic                        flush
`endif
);

  logic                        flush_i;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]       acc_q [RATIO];
  logic [DATA_WIDTH-1:0]       acc_d [RATIO];
  logic                        out_valid_q, out_valid_d;
  logic [DATA_WIDTH*RATIO-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]        out_cnt_q, out_cnt_d;
  logic                        free;
  logic                        accept;
  logic                        full_load;
  logic                        flush_load;
  logic                        load;
  logic [CNT_WIDTH-1:0]        eff_cnt;
  logic [DATA_WIDTH*RATIO-1:0] packed_word;

`ifdef CFS_STREAM_PACKER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign free       = !out_valid_q || out_ready;
  assign in_ready   = (cnt_q != CNT_WIDTH'(RATIO - 1)) || free;
  assign accept     = in_valid && in_ready;
  assign eff_cnt    = cnt_q + CNT_WIDTH'(accept);
  assign full_load  = accept && (cnt_q == CNT_WIDTH'(RATIO - 1));
  // A flush reaching a full count is just a normal full load.
  assign flush_load = flush_i && free && (eff_cnt != '0) && (eff_cnt != CNT_WIDTH'(RATIO));
  assign load       = full_load || flush_load;

  // Lanes below cnt come from the accumulator, lane cnt from the incoming word, the rest are zero.
  // The top accumulator lane is never written, so it stays at its reset value.
  always_comb begin
    packed_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      acc_d[k] = acc_q[k];
      if (CNT_WIDTH'(k) < cnt_q) begin
        packed_word[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k];
      end else if ((CNT_WIDTH'(k) == cnt_q) && accept) begin
        packed_word[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
      if (accept && !load && (CNT_WIDTH'(k) == cnt_q)) begin
        acc_d[k] = in_data;
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    if (load) begin
      cnt_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = packed_word;
      out_cnt_d   = eff_cnt;
    end else begin
      if (accept) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      for (int k = 0; k < RATIO; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      for (int k = 0; k < RATIO; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_cfs_stream_packer.sv
// Scoreboard bench for cfs_stream_packer: reference model groups accepted words into queues, monitor pops and compares.
module tb_cfs_stream_packer;
  localparam int DW = 8;
  localparam int R  = 4;
  localparam int CW = $clog2(R + 1);
`ifdef CFS_STREAM_PACKER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  typedef struct {
    logic [R*DW-1:0] data;
    logic [CW-1:0]   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [R*DW-1:0] out_data;
  logic [CW-1:0] out_cnt;
  logic          out_ready;
  logic          flush;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] send_q [$];
  logic [DW-1:0] grp [$];
  exp_t          exp_q [$];

  logic          acc_s = 1'b0;
  logic          flush_s = 1'b0;
  logic [DW-1:0] word_s = '0;
  logic          stall_prev = 1'b0;
  logic [R*DW-1:0] prev_data = '0;
  logic [CW-1:0] prev_cnt = '0;

  cfs_stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_cnt(out_cnt),
    .out_ready(out_ready)
`ifdef CFS_STREAM_PACKER_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: a group of accepted words becomes one packed word; unused lanes read as zero.
  task automatic emit_group();
    exp_t e;
    e.data = '0;
    for (int i = 0; i < grp.size(); i++) e.data[i*DW +: DW] = grp[i];
    e.cnt = CW'(grp.size());
    exp_q.push_back(e);
    grp.delete();
  endtask

  always @(negedge clk) begin
    acc_s   = !reset && in_valid && in_ready;
    flush_s = !reset && flush;
    word_s  = in_data;
  end

  // Output register is free when the scoreboard holds nothing undrained.
  always @(posedge clk) begin
    if (!reset) begin
      if (acc_s) grp.push_back(word_s);
      if (grp.size() == R) emit_group();
      else if (FLUSH_EN && flush_s && grp.size() > 0 && exp_q.size() == 0) emit_group();
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      grp.delete();
      exp_q.delete();
      stall_prev = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_out_cnt", 64'(out_cnt), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
    end else begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      chk("in_ready", 64'(in_ready),
          64'((grp.size() != R - 1) || (exp_q.size() == 0) || out_ready));
      if (stall_prev) begin
        chk("stable_data", 64'(out_data), 64'(prev_data));
        chk("stable_cnt", 64'(out_cnt), 64'(prev_cnt));
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_cnt", 64'(out_cnt), 64'(e.cnt));
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_cnt   = out_cnt;
    end
  end

  task automatic drive_cycle(input bit rdy, input int vprob, input bit fl);
    @(posedge clk);
    #1;
    out_ready = rdy;
    flush     = fl;
    if (send_q.size() > 0 && int'($urandom_range(99)) < vprob) begin
      in_valid = 1'b1;
      in_data  = send_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
    end
    @(negedge clk);
    if (in_valid && in_ready) void'(send_q.pop_front());
  endtask

  task automatic run_until_empty(input bit rdy, input int vprob);
    for (int c = 0; c < 300 && send_q.size() > 0; c++) drive_cycle(rdy, vprob, 1'b0);
    chk("send_done", 64'(send_q.size()), 64'(0));
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive_cycle(1'b1, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    send_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_until_empty(1'b1, 100);
    idle(3);

    for (int i = 0; i < 12; i++) send_q.push_back(DW'(8'h50 + i));
    for (int c = 0; c < 40; c++) drive_cycle(c >= 20, 100, 1'b0);
    chk("bp_send_done", 64'(send_q.size()), 64'(0));
    idle(2);

    send_q = '{8'hAA, 8'hBB};
    run_until_empty(1'b1, 100);
    @(posedge clk); #1 reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    send_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_until_empty(1'b1, 100);
    idle(3);

`ifdef CFS_STREAM_PACKER_FLUSH_EN
    send_q = '{8'h11, 8'h22};
    run_until_empty(1'b1, 100);
    drive_cycle(1'b1, 0, 1'b1);
    idle(2);
    send_q = '{8'h11, 8'h22};
    run_until_empty(1'b1, 100);
    send_q = '{8'h33};
    drive_cycle(1'b1, 100, 1'b1);
    chk("flush_with_word", 64'(send_q.size()), 64'(0));
    idle(2);
    drive_cycle(1'b1, 0, 1'b1);
    drive_cycle(1'b1, 0, 1'b1);
    idle(2);
    send_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    run_until_empty(1'b0, 100);
    for (int c = 0; c < 3; c++) drive_cycle(1'b0, 0, 1'b1);
    drive_cycle(1'b1, 0, 1'b1);
    idle(3);
`endif

    for (int i = 0; i < 160; i++) send_q.push_back(DW'($urandom));
    for (int c = 0; c < 2000 && send_q.size() > 0; c++)
      drive_cycle($urandom_range(99) < 60, 70, 1'b0);
    chk("rand_send_done", 64'(send_q.size()), 64'(0));

    for (int c = 0; c < 100 && exp_q.size() > 0; c++) drive_cycle(1'b1, 0, 1'b0);
    idle(2);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("no_partial", 64'(grp.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
